cpu_ifetch_q: RTL and testbench

CPU_IFETCH_Q -- requirements
Module: cpu_ifetch_q

---
 rtl/cpu_pkg.sv | 18 +
 rtl/cpu_fifo.sv | 61 ++++++
 rtl/cpu_ifetch_q.sv | 145 ++++++++++++++
 tb/tb_cpu_ifetch_q.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared fetch-unit types and defaults.
// Imported by the prefetch queue and the fetch stage.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifq_entry_t;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cpu_fifo.sv
// Generic synchronous FIFO with flush.
// Accepts a push while full when a pop happens on the same edge.
module cpu_fifo #(
  parameter type T     = logic [63:0],
  parameter int  DEPTH = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_flush,
  input  logic                         i_push,
  input  T                             i_din,
  input  logic                         i_pop,
  output T                             o_dout,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);

  T              r_mem [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  logic          w_wr;
  logic          w_rd;

  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;
  assign o_dout  = r_mem[r_rp];

  assign w_wr = i_push & (~o_full | i_pop);
  assign w_rd = i_pop & ~o_empty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      unique case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr && !i_flush) r_mem[r_wp] <= i_din;
  end

endmodule

// File: rtl/cpu_ifetch_q.sv
// Instruction fetch unit with prefetch queue feeding decode (p2).
// Redirects discard in-flight responses by counting them out.
module cpu_ifetch_q
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC        = RESET_PC_DEF,
  parameter int          QDEPTH          = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        p2_bubble,
  input  logic        p3_jump_taken,
  input  logic [31:0] p3_jump_addr,
  output logic        cpui_request,
  output logic [31:0] cpui_addr,
  input  logic        cpui_ready,
  input  logic [31:0] cpui_rdata,
  input  logic        cpui_ack,
  output logic [31:0] p2_instr,
  output logic [31:0] p2_pc,
  output logic        p2_instr_valid,
  output logic        overflow
);

  localparam int OW = $clog2(MAX_OUTSTANDING+1);
  localparam int QW = $clog2(QDEPTH+1);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_ack_pc;
  logic [OW-1:0] r_outst;
  logic [OW-1:0] r_discard;
  logic [31:0]   r_p2_instr;
  logic [31:0]   r_p2_pc;
  logic          r_p2_valid;
  logic          r_overflow;

  ifq_entry_t    w_ack_ent;
  ifq_entry_t    w_head;
  logic          w_full;
  logic          w_empty;
  logic [QW-1:0] w_count;
  logic [31:0]   w_inflight;
  logic          w_hold;
  logic          w_req;
  logic          w_accept;
  logic          w_ack_keep;
  logic          w_ack_drop;
  logic          w_bypass;
  logic          w_pop;
  logic          w_push;

  assign w_hold     = stall | p2_bubble;
  assign w_inflight = 32'(w_count) + 32'(r_outst);

  // Every request must have a queue slot reserved for its response.
  assign w_req = !reset && !p3_jump_taken
              && (32'(r_outst) < 32'(MAX_OUTSTANDING))
              && (w_inflight < 32'(QDEPTH));

  assign w_accept   = w_req & cpui_ready;
  assign w_ack_keep = cpui_ack & ~p3_jump_taken & (r_discard == '0);
  assign w_ack_drop = cpui_ack & ~p3_jump_taken & (r_discard != '0);
  assign w_bypass   = w_ack_keep & w_empty & ~w_hold;
  assign w_pop      = ~p3_jump_taken & ~w_hold & ~w_empty;
  assign w_push     = w_ack_keep & ~w_bypass;

  assign w_ack_ent.pc    = r_ack_pc;
  assign w_ack_ent.instr = cpui_rdata;

  cpu_fifo #(
    .T     (ifq_entry_t),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_flush (p3_jump_taken),
    .i_push  (w_push),
    .i_din   (w_ack_ent),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_ack_pc   <= RESET_PC;
      r_outst    <= '0;
      r_discard  <= '0;
    end else begin
      unique case ({w_accept, cpui_ack})
        2'b10:   r_outst <= r_outst + 1'b1;
        2'b01:   r_outst <= r_outst - 1'b1;
        default: r_outst <= r_outst;
      endcase
      if (p3_jump_taken) begin
        r_fetch_pc <= word_align(p3_jump_addr);
        r_ack_pc   <= word_align(p3_jump_addr);
        r_discard  <= r_outst - OW'(cpui_ack);
      end else begin
        if (w_accept)   r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_ack_keep) r_ack_pc   <= r_ack_pc + 32'd4;
        if (w_ack_drop) r_discard  <= r_discard - 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_p2_instr <= '0;
      r_p2_pc    <= '0;
      r_p2_valid <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      if (p3_jump_taken) begin
        r_p2_valid <= 1'b0;
      end else if (!w_hold) begin
        if (!w_empty) begin
          r_p2_instr <= w_head.instr;
          r_p2_pc    <= w_head.pc;
          r_p2_valid <= 1'b1;
        end else if (w_bypass) begin
          r_p2_instr <= cpui_rdata;
          r_p2_pc    <= r_ack_pc;
          r_p2_valid <= 1'b1;
        end else begin
          r_p2_valid <= 1'b0;
        end
      end
    end
  end

  assign cpui_request   = w_req;
  assign cpui_addr      = r_fetch_pc;
  assign p2_instr       = r_p2_instr;
  assign p2_pc          = r_p2_pc;
  assign p2_instr_valid = r_p2_valid;
  assign overflow       = r_overflow;

endmodule

// File: tb/tb_cpu_ifetch_q.sv
// Scoreboard bench for cpu_ifetch_q with an in-order memory model.
// Expected p2 entries are queued by stimulus and popped by a monitor.
module tb_cpu_ifetch_q;
  import cpu_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        p2_bubble = 1'b0;
  logic        p3_jump_taken = 1'b0;
  logic [31:0] p3_jump_addr = '0;
  logic        cpui_request;
  logic [31:0] cpui_addr;
  logic        cpui_ready = 1'b0;
  logic [31:0] cpui_rdata = '0;
  logic        cpui_ack = 1'b0;
  logic [31:0] p2_instr;
  logic [31:0] p2_pc;
  logic        p2_instr_valid;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 1;
  bit rdy_all = 1'b1;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t      mq[$];
  ifq_entry_t exp_q[$];
  int         seen_cyc[$];
  int         n_seen = 0;
  bit         arm_first = 1'b0;
  logic [31:0] first_addr = 32'hDEAD_BEEF;
  int         first_cyc = 0;

  cpu_ifetch_q #(
    .RESET_PC        (32'h0000_0000),
    .QDEPTH          (4),
    .MAX_OUTSTANDING (2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .p2_bubble      (p2_bubble),
    .p3_jump_taken  (p3_jump_taken),
    .p3_jump_addr   (p3_jump_addr),
    .cpui_request   (cpui_request),
    .cpui_addr      (cpui_addr),
    .cpui_ready     (cpui_ready),
    .cpui_rdata     (cpui_rdata),
    .cpui_ack       (cpui_ack),
    .p2_instr       (p2_instr),
    .p2_pc          (p2_pc),
    .p2_instr_valid (p2_instr_valid),
    .overflow       (overflow)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] memval(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) begin
      ifq_entry_t e;
      e.pc    = start + 32'(4 * i);
      e.instr = memval(e.pc);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_seen(input int target, input int budget,
                           input bit bub);
    int k;
    k = 0;
    while (n_seen < target && k < budget) begin
      @(negedge clock);
      p2_bubble = bub && k[0];
      k++;
    end
    p2_bubble = 1'b0;
    chk("seen_count", 32'(n_seen), 32'(target));
  endtask

  // Memory: one response per cycle, in order, lat edges after accept.
  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      mq.delete();
      cpui_ack   = 1'b0;
      cpui_rdata = '0;
      cpui_ready = rdy_all;
    end else begin
      if (mq.size() > 0 && mq[0].due <= cyc) begin
        cpui_ack   = 1'b1;
        cpui_rdata = memval(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        cpui_ack   = 1'b0;
        cpui_rdata = '0;
      end
      cpui_ready = rdy_all || (cyc % 3 != 0);
    end
    #4;
    if (!reset && cpui_request && cpui_ready) begin
      mq.push_back('{addr: cpui_addr, due: cyc + lat});
      if (arm_first) begin
        first_addr = cpui_addr;
        first_cyc  = cyc;
        arm_first  = 1'b0;
      end
    end
  end

  // Monitor: an entry is consumed on an edge where p2 advances.
  always @(negedge clock) begin
    #4;
    if (!reset && p2_instr_valid && !stall && !p2_bubble
        && !p3_jump_taken) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_p2: got pc %h with none expected",
                 p2_pc);
      end else begin
        ifq_entry_t e;
        e = exp_q.pop_front();
        chk("p2_pc", p2_pc, e.pc);
        chk("p2_instr", p2_instr, e.instr);
      end
      seen_cyc.push_back(cyc);
      n_seen++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int base;
    repeat (3) @(negedge clock);
    #3;
    chk("rst_request", 32'(cpui_request), 32'd0);
    chk("rst_valid", 32'(p2_instr_valid), 32'd0);
    chk("rst_p2_pc", p2_pc, 32'h0);
    chk("rst_p2_instr", p2_instr, 32'h0);
    chk("rst_overflow", 32'(overflow), 32'd0);

    // Streaming after reset, latency one edge, no holds.
    @(negedge clock);
    #1 reset = 1'b0;
    arm_first = 1'b1;
    #2;
    chk("req_after_reset", 32'(cpui_request), 32'd1);
    chk("addr_after_reset", cpui_addr, 32'h0);
    expect_seq(32'h0, 4);
    wait_seen(4, 60, 1'b0);
    chk("first_addr", first_addr, 32'h0);
    chk("bypass_latency", 32'(seen_cyc[0] - first_cyc), 32'd2);
    chk("no_gap", 32'(seen_cyc[3] - seen_cyc[0]), 32'd3);

    // Stall five edges with 0x10 in p2.
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #3;
      chk("stall_hold_pc", p2_pc, 32'h10);
      chk("stall_hold_valid", 32'(p2_instr_valid), 32'd1);
      if (i == 4) chk("req_stops_full", 32'(cpui_request), 32'd0);
      @(negedge clock);
    end
    stall = 1'b0;
    expect_seq(32'h10, 12);
    wait_seen(16, 100, 1'b0);

    // Jump with two requests in flight.
    lat = 2;
    expect_seq(32'h40, 40);
    k = 0;
    do begin
      @(negedge clock);
      #2;
      k++;
    end while ((mq.size() + int'(cpui_ack)) != 2 && k < 60);
    chk("inflight_at_jump", 32'(mq.size() + int'(cpui_ack)), 32'd2);
    p3_jump_taken = 1'b1;
    p3_jump_addr  = 32'h1000;
    exp_q.delete();
    expect_seq(32'h1000, 8);
    @(negedge clock);
    p3_jump_taken = 1'b0;
    base = n_seen;
    wait_seen(base + 8, 120, 1'b0);

    // Misaligned jump coincident with an ack and a stall.
    expect_seq(32'h1020, 30);
    k = 0;
    do begin
      @(negedge clock);
      #2;
      k++;
    end while (!cpui_ack && k < 60);
    chk("ack_at_jump", 32'(cpui_ack), 32'd1);
    stall = 1'b1;
    p3_jump_taken = 1'b1;
    p3_jump_addr  = 32'h1002;
    exp_q.delete();
    expect_seq(32'h1000, 6);
    arm_first = 1'b1;
    base = n_seen;
    #1;
    chk("req_low_in_jump", 32'(cpui_request), 32'd0);
    @(negedge clock);
    p3_jump_taken = 1'b0;
    #3;
    chk("valid_low_after_jump", 32'(p2_instr_valid), 32'd0);
    repeat (2) @(negedge clock);
    stall = 1'b0;
    wait_seen(base + 6, 120, 1'b0);
    chk("first_fetch_after_jump", first_addr, 32'h1000);

    // Address wrap with irregular ready and decoder bubbles.
    rdy_all = 1'b0;
    p3_jump_taken = 1'b1;
    p3_jump_addr  = 32'hFFFF_FFF8;
    exp_q.delete();
    expect_seq(32'hFFFF_FFF8, 5);
    base = n_seen;
    @(negedge clock);
    p3_jump_taken = 1'b0;
    wait_seen(base + 5, 300, 1'b1);

    // Reset while a response is still pending.
    expect_seq(32'h0000_000C, 30);
    k = 0;
    do begin
      @(negedge clock);
      #2;
      k++;
    end while (mq.size() == 0 && k < 60);
    chk("pending_at_reset", 32'(mq.size() > 0), 32'd1);
    reset = 1'b1;
    lat = 1;
    rdy_all = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_request", 32'(cpui_request), 32'd0);
    chk("midrst_valid", 32'(p2_instr_valid), 32'd0);
    chk("midrst_p2_pc", p2_pc, 32'h0);
    chk("midrst_p2_instr", p2_instr, 32'h0);
    chk("midrst_overflow", 32'(overflow), 32'd0);
    repeat (2) @(negedge clock);
    #1 reset = 1'b0;
    arm_first = 1'b1;
    base = n_seen;
    expect_seq(32'h0, 4);
    wait_seen(base + 4, 60, 1'b0);
    chk("refetch_addr", first_addr, 32'h0);
    chk("final_overflow", 32'(overflow), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
